conflict_detector_mc: RTL
=========================

Name: conflict_detector_mc

Overview:
- Multi-channel, parametrised implication conflict detector for the SAT solver datapath.
- Accepts up to NUM_CH implications per cycle from the clause evaluators and checks each against a per-variable assignment memory and against the other channels in the same beat.
- Reports a sticky conflict to the Solver, or forwards new assignments to the Imply Stack through a valid/ready output FIFO.
- Records the decision level of each assignment and supports backtracking by invalidating every assignment above a target level.

Parameters:
- VAR_COUNT, 512, number of variables in the assignment memory.
- VAR_W, $clog2(VAR_COUNT), variable index width.
- NUM_CH, 2, implication input channels per cycle.
- LEVEL_W, 9, decision-level width.
- FIFO_DEPTH, 8, output FIFO entries; power of 2, at least NUM_CH.

Ports:
- clock, in, 1, system clock.
- reset_n, in, 1, asynchronous active-low reset.
- imp_valid, in, NUM_CH, per-channel implication valid.
- imp_var, in, NUM_CH*VAR_W, per-channel implied variable index.
- imp_val, in, NUM_CH, per-channel implied value.
- cur_level, in, LEVEL_W, decision level applied to this beat's assignments.
- in_ready, out, 1, beat accepted when any imp_valid bit is set and in_ready=1.
- bt_req, in, 1, backtrack request pulse.
- bt_level, in, LEVEL_W, backtrack target level; entries with level > bt_level are cleared.
- bt_done, out, 1, one-cycle pulse when the sweep completes.
- conflict, out, 1, sticky conflict flag.
- conflict_var, out, VAR_W, variable index of the first conflicting channel.
- busy, out, 1, high during a sweep.
- out_valid, out, 1, FIFO head valid.
- out_ready, in, 1, Imply Stack ready.
- out_var, out, VAR_W, FIFO head variable index.
- out_val, out, 1, FIFO head value.
- fifo_count, out, $clog2(FIFO_DEPTH)+1, current FIFO occupancy.

Behaviour:
- Reset (async, reset_n=0): all memory valid bits 0; FSM=IDLE.
- Reset output values: conflict=0, conflict_var=0, bt_done=0, busy=0, FIFO empty (out_valid=0, fifo_count=0).
- Memory entry: {val, level, valid}.
- FSM states: IDLE, CONFLICT, SWEEP.
- in_ready = (state==IDLE) && (FIFO_DEPTH - fifo_count >= NUM_CH), so one beat can never overflow the FIFO.
- Per-channel classification in an accepted beat. Channel k is:
  - a conflict if the memory entry is valid with a differing val, or a lower valid channel j<k names the same var with a differing val;
  - redundant if the memory entry is valid with equal val, or a lower channel names the same var with equal val;
  - otherwise new.
- Beat with no conflict:
  - Every new channel writes {imp_val, cur_level, 1} on the clock edge.
  - New channels are pushed into the FIFO in ascending channel order.
  - Redundant channels neither write nor push.
  - Write-to-check latency is 1 cycle: the next beat sees the updates.
- Beat with any conflict:
  - The whole beat is discarded: no writes, no pushes.
  - Next cycle: conflict=1, conflict_var = var of the lowest conflicting channel, FSM -> CONFLICT.
  - conflict holds until bt_req.
- CONFLICT state: in_ready=0; the FIFO keeps draining.
- bt_req while in IDLE or CONFLICT:
  - On that edge: flush the FIFO (count 0), clear conflict, latch bt_level, FSM -> SWEEP, busy=1.
  - Any imp beat presented in the same cycle is ignored.
- SWEEP:
  - Visit one index per cycle, 0..VAR_COUNT-1; clear valid where level > latched level.
  - After the last index: bt_done=1 for one cycle, busy=0, FSM -> IDLE.
  - Sweep length is VAR_COUNT cycles.
  - bt_req during SWEEP is ignored.
- FIFO:
  - Pop when out_valid && out_ready.
  - A simultaneous push and pop in one cycle is legal; count updates by pushes minus pop.
  - Pointers wrap modulo FIFO_DEPTH.
  - out_var and out_val are stable while out_valid=1 and out_ready=0.
- Reset asserted mid-sweep or mid-conflict returns immediately to the reset state.
- imp_var >= VAR_COUNT is illegal; behaviour is undefined and flagged by an assertion.

Decomposition:
- Package conflict_detector_pkg:
  - var_info_t struct {val, level, valid};
  - state enum {IDLE, CONFLICT, SWEEP};
  - default-parameter constants.
- Sub-module imply_fifo: parametrised on DEPTH, data width and push width NUM_CH.
  - Interface: multi-push, single-pop, valid/ready.
  - Instantiated once.

Test Plan:
- Single channel: var 5 val 1 at level 2, then var 5 val 0 -> first pushes (5,1); second gives conflict=1, conflict_var=5 next cycle, and the FIFO holds only (5,1).
- Same-beat conflict: ch0=(7,1), ch1=(7,0) -> conflict=1, conflict_var=7; memory entry 7 stays invalid; no push.
- Same-beat redundancy: ch0=(9,0), ch1=(9,0) -> exactly one push (9,0).
- Re-implying existing (9,0) -> no push.
- Backpressure: out_ready=0 and 4 beats of 2 new vars with FIFO_DEPTH=8 -> in_ready drops when count=7 or 8; raising out_ready drains in channel order.
- Backtrack: vars 1@L1, 2@L2, 3@L3, then conflict, then bt_req with bt_level=1 -> conflict clears and FIFO flushes immediately; busy for 512 cycles; bt_done pulse.
  - After the sweep, re-implying 2 and 3 with opposite values is accepted as new; re-implying 1 opposite conflicts.
- Async reset mid-sweep (reset_n low at sweep cycle 100) -> outputs at reset values immediately; all vars invalid afterwards.

Source files
------------

// File: rtl/conflict_detector_pkg.sv
// Shared types and default sizing for the multi-channel implication conflict detector.
package conflict_detector_pkg;

  localparam int unsigned DEF_VAR_COUNT  = 512;
  localparam int unsigned DEF_NUM_CH     = 2;
  localparam int unsigned DEF_LEVEL_W    = 9;
  localparam int unsigned DEF_FIFO_DEPTH = 8;

  // Levels are stored zero-extended so one entry type serves any LEVEL_W up to this width.
  localparam int unsigned LEVEL_MAX_W    = 16;

  typedef struct packed {
    logic                   val;
    logic [LEVEL_MAX_W-1:0] level;
    logic                   valid;
  } var_info_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CONFLICT = 2'd1,
    ST_SWEEP    = 2'd2
  } state_e;

endpackage

// File: rtl/imply_fifo.sv
// Multi-push, single-pop FIFO carrying accepted implications to the Imply Stack.
module imply_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned DW    = 10,
  parameter int unsigned NPUSH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush_i,
  input  logic [NPUSH-1:0]        push_en_i,
  input  logic [NPUSH*DW-1:0]     push_data_i,
  input  logic                    pop_i,
  output logic [DW-1:0]           head_o,
  output logic                    valid_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DW-1:0]    mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] n_push_c;
  logic [PTR_W-1:0] slot_c [NPUSH];
  logic             pop_c;

  assign valid_o = (count_q != '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign pop_c   = pop_i & valid_o;

  // Enabled push lanes are packed into consecutive slots in ascending lane order.
  always_comb begin
    n_push_c = '0;
    for (int k = 0; k < NPUSH; k++) begin
      slot_c[k] = wr_ptr_q + PTR_W'(n_push_c);
      n_push_c  = n_push_c + CNT_W'(push_en_i[k]);
    end
    wr_ptr_d = wr_ptr_q + PTR_W'(n_push_c);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_c);
    count_d  = count_q + n_push_c - CNT_W'(pop_c);
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (!flush_i) begin
      for (int k = 0; k < NPUSH; k++) begin
        if (push_en_i[k]) mem_q[slot_c[k]] <= push_data_i[k*DW +: DW];
      end
    end
  end

endmodule

// File: rtl/conflict_detector_mc.sv
// Checks up to NUM_CH implications per beat against the assignment memory and each other;
// raises a sticky conflict or forwards new assignments, and backtracks by a level sweep.
module conflict_detector_mc
  import conflict_detector_pkg::*;
#(
  parameter int unsigned VAR_COUNT  = DEF_VAR_COUNT,
  parameter int unsigned VAR_W      = $clog2(VAR_COUNT),
  parameter int unsigned NUM_CH     = DEF_NUM_CH,
  parameter int unsigned LEVEL_W    = DEF_LEVEL_W,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [NUM_CH-1:0]             imp_valid,
  input  logic [NUM_CH*VAR_W-1:0]       imp_var,
  input  logic [NUM_CH-1:0]             imp_val,
  input  logic [LEVEL_W-1:0]            cur_level,
  output logic                          in_ready,
  input  logic                          bt_req,
  input  logic [LEVEL_W-1:0]            bt_level,
  output logic                          bt_done,
  output logic                          conflict,
  output logic [VAR_W-1:0]              conflict_var,
  output logic                          busy,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [VAR_W-1:0]              out_var,
  output logic                          out_val,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned DW     = VAR_W + 1;
  localparam int unsigned VAR_W1 = VAR_W + 1;

  state_e             state_q, state_d;
  var_info_t          mem_q [VAR_COUNT];
  logic               conflict_q, conflict_d;
  logic [VAR_W-1:0]   conflict_var_q, conflict_var_d;
  logic               bt_done_q, bt_done_d;
  logic               busy_q, busy_d;
  logic [LEVEL_W-1:0] bt_level_q, bt_level_d;
  logic [VAR_W-1:0]   sweep_idx_q, sweep_idx_d;

  logic [VAR_W-1:0]        ch_var [NUM_CH];
  logic [NUM_CH-1:0]       ch_conf, ch_red, ch_new;
  logic [NUM_CH-1:0]       push_en_c;
  logic [NUM_CH*DW-1:0]    push_data_c;
  logic [VAR_W-1:0]        first_var_c;
  logic                    any_conf_c;
  logic                    accept_c;
  logic                    flush_c;
  logic                    sweep_clr_c;
  logic [DW-1:0]           head_w;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign ch_var[k] = imp_var[k*VAR_W +: VAR_W];

    a_var_range: assert property (@(posedge clock) disable iff (!reset_n)
      imp_valid[k] |-> ({1'b0, ch_var[k]} < VAR_W1'(VAR_COUNT)));
  end

  // Classify each channel against the memory and against lower channels in the same beat.
  always_comb begin
    ch_conf     = '0;
    ch_red      = '0;
    ch_new      = '0;
    push_data_c = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (imp_valid[k]) begin
        if (mem_q[ch_var[k]].valid) begin
          if (mem_q[ch_var[k]].val != imp_val[k]) ch_conf[k] = 1'b1;
          else                                    ch_red[k]  = 1'b1;
        end
        for (int j = 0; j < k; j++) begin
          if (imp_valid[j] && (ch_var[j] == ch_var[k])) begin
            if (imp_val[j] != imp_val[k]) ch_conf[k] = 1'b1;
            else                          ch_red[k]  = 1'b1;
          end
        end
      end
      ch_new[k] = imp_valid[k] & ~ch_conf[k] & ~ch_red[k];
      push_data_c[k*DW +: DW] = {ch_var[k], imp_val[k]};
    end
  end

  always_comb begin
    first_var_c = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (ch_conf[k]) first_var_c = ch_var[k];
    end
  end

  assign any_conf_c = |ch_conf;
  assign in_ready   = (state_q == ST_IDLE) &&
                      ((CNT_W'(FIFO_DEPTH) - fifo_count) >= CNT_W'(NUM_CH));
  // A backtrack request takes priority over any beat offered in the same cycle.
  assign accept_c   = in_ready && (|imp_valid) && !bt_req;
  assign push_en_c  = {NUM_CH{accept_c & ~any_conf_c}} & ch_new;

  always_comb begin
    state_d        = state_q;
    conflict_d     = conflict_q;
    conflict_var_d = conflict_var_q;
    bt_done_d      = 1'b0;
    busy_d         = busy_q;
    bt_level_d     = bt_level_q;
    sweep_idx_d    = sweep_idx_q;
    flush_c        = 1'b0;
    sweep_clr_c    = 1'b0;
    case (state_q)
      ST_IDLE, ST_CONFLICT: begin
        if (bt_req) begin
          flush_c     = 1'b1;
          conflict_d  = 1'b0;
          bt_level_d  = bt_level;
          busy_d      = 1'b1;
          sweep_idx_d = '0;
          state_d     = ST_SWEEP;
        end else if ((state_q == ST_IDLE) && accept_c && any_conf_c) begin
          conflict_d     = 1'b1;
          conflict_var_d = first_var_c;
          state_d        = ST_CONFLICT;
        end
      end
      ST_SWEEP: begin
        sweep_clr_c = mem_q[sweep_idx_q].valid &&
                      (mem_q[sweep_idx_q].level > LEVEL_MAX_W'(bt_level_q));
        if (sweep_idx_q == VAR_W'(VAR_COUNT - 1)) begin
          sweep_idx_d = '0;
          busy_d      = 1'b0;
          bt_done_d   = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          sweep_idx_d = sweep_idx_q + VAR_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      conflict_q     <= 1'b0;
      conflict_var_q <= '0;
      bt_done_q      <= 1'b0;
      busy_q         <= 1'b0;
      bt_level_q     <= '0;
      sweep_idx_q    <= '0;
    end else begin
      state_q        <= state_d;
      conflict_q     <= conflict_d;
      conflict_var_q <= conflict_var_d;
      bt_done_q      <= bt_done_d;
      busy_q         <= busy_d;
      bt_level_q     <= bt_level_d;
      sweep_idx_q    <= sweep_idx_d;
    end
  end

  // Assignment memory: new channels write, the sweep invalidates deeper levels.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < VAR_COUNT; i++) mem_q[i] <= '0;
    end else begin
      if (sweep_clr_c) mem_q[sweep_idx_q].valid <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        if (push_en_c[k]) begin
          mem_q[ch_var[k]] <= '{val: imp_val[k], level: LEVEL_MAX_W'(cur_level), valid: 1'b1};
        end
      end
    end
  end

  imply_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (DW),
    .NPUSH (NUM_CH)
  ) u_fifo (
    .clk         (clock),
    .rst_n       (reset_n),
    .flush_i     (flush_c),
    .push_en_i   (push_en_c),
    .push_data_i (push_data_c),
    .pop_i       (out_ready),
    .head_o      (head_w),
    .valid_o     (out_valid),
    .count_o     (fifo_count)
  );

  assign out_var      = head_w[DW-1:1];
  assign out_val      = head_w[0];
  assign conflict     = conflict_q;
  assign conflict_var = conflict_var_q;
  assign bt_done      = bt_done_q;
  assign busy         = busy_q;

endmodule
